axi_udp_arp_tx: RTL and testbench
=================================

# axi_udp_arp_tx

ARP frame transmitter for the UDP offload stack. It accepts one ARP command (request or reply) through a valid/ready handshake and serializes a complete Ethernet+ARP frame, without FCS, onto an 8-bit AXI4-Stream master. It sits beside the ARP receive path: the receive side issues reply commands for incoming requests, and the resolver issues request commands for unknown IPs. Its output feeds the TX frame arbiter ahead of the MAC.

## Interface
Parameters: none. All protocol constants come from `axi_udp_pkg`.

Ports:
- `clk` in 1 — single clock for all logic.
- `rst` in 1 — asynchronous, active-high reset.
- `local_mac` in 48 — own MAC address; sampled at command accept.
- `local_ip` in 32 — own IPv4 address; sampled at command accept.
- `cmd_valid` in 1 — command present.
- `cmd_ready` out 1 — command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_oper` in 16 — `ARP_OPER_REQUEST` or `ARP_OPER_REPLY`.
- `cmd_tha` in 48 — target MAC; used only for replies.
- `cmd_tpa` in 32 — target IP.
- `m_axis_tdata` out 8 — frame byte.
- `m_axis_tvalid` out 1 — byte valid.
- `m_axis_tready` in 1 — downstream ready.
- `m_axis_tlast` out 1 — last byte of frame.
- `busy` out 1 — a frame is in progress.

## Operation
- States are `IDLE` and `SEND`.
- `cmd_ready` = (state == `IDLE`).
- On accept, latch `cmd_oper`, `cmd_tha`, `cmd_tpa`, `local_mac` and `local_ip`, clear the byte counter, and go to `SEND`.
- Byte order is big-endian, MSB first per field, offsets 0–41:
  - DA: `BROADCAST_MAC` if request, else THA.
  - SA: `local_mac`.
  - Ethertype: `ETHERTYPE_ARP`.
  - `ARP_HW_TYPE`, `ARP_PROTO_TYPE`, `ARP_HW_SIZE`, `ARP_PROTO_SIZE`.
  - OPER.
  - SHA = `local_mac`, SPA = `local_ip`.
  - THA: all zero if request, else latched THA.
  - TPA.
- An illegal `cmd_oper` (neither 1 nor 2) is transmitted verbatim. DA and THA then follow the reply rule.
- The byte counter is 6 bits and advances only on `tvalid && tready`.
- `tlast` is high on the final byte, which is frame length − 1.
- The transfer carrying `tlast` returns the FSM to `IDLE`. The counter never wraps.
- Command inputs are ignored while in `SEND`. Changes to `local_mac`/`local_ip` mid-frame do not affect the frame.

## Timing
- Reset values: `cmd_ready`=1 (while reset is deasserted in `IDLE`), `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0.
- During reset assertion, `cmd_ready`=0.
- Command accepted in cycle N → byte 0 valid in cycle N+1.
- Back-to-back throughput is 1 byte per cycle while `tready` is held high.
- `tdata` and `tlast` are registered and held stable while `tvalid && !tready`. `tvalid` never drops before its handshake.
- After the `tlast` handshake in cycle M:
  - `tvalid`=0 and `cmd_ready`=1 in M+1.
  - The next frame starts no earlier than M+2, which gives a 1-cycle minimum gap.
- `busy` = (state == `SEND`).
- Reset mid-frame aborts immediately (asynchronously): outputs go to their reset values and the truncated frame gets no `tlast`. Downstream must discard it.

## Configuration
- `AXI_UDP_ARP_TX_PAD_EN` defined:
  - Frame padded with 0x00 bytes from offset 42 to 59.
  - Length is 60, the Ethernet minimum without FCS; `tlast` at offset 59.
- Macro undefined:
  - Length is 42; `tlast` at offset 41.
  - Padding is left to the MAC.

## Structure
- Add to `axi_udp_pkg`:
  - `ARP_FRAME_LEN` = 42.
  - `ETH_MIN_FRAME_LEN` = 60.
  - Field offset constants: DA=0, SA=6, ETYPE=12, HTYPE=14, PTYPE=16, HLEN=18, PLEN=19, OPER=20, SHA=22, SPA=28, THA=32, TPA=38.
  - Typedef `arp_cmd_t` (oper, tha, tpa).
- The FSM enum stays local to the module.
- No sub-module. Byte selection is a counter-indexed combinational mux feeding the output register.

## Test plan
- Reply, `local_mac`=02:00:00:00:00:01, `local_ip`=10.0.0.1, THA=AA:BB:CC:DD:EE:FF, TPA=10.0.0.2, `tready`=1 → 42 bytes (60 with pad):
  - starts AA BB CC DD EE FF 02 00 00 00 00 01 08 06 00 01 08 00 06 04 00 02;
  - ends …0A 00 00 02;
  - `tlast` only on the final byte;
  - byte 0 appears the cycle after accept.
- Request, TPA=192.168.1.10 → DA = FF×6, OPER = 00 01, THA (bytes 32–37) = 00×6, bytes 38–41 = C0 A8 01 0A.
- Random `tready` backpressure (50%) on the reply frame → identical byte sequence; `tdata`/`tlast` stable while stalled; no dropped or duplicated bytes.
- `cmd_valid` held high for two commands → `cmd_ready` low during the frame; second frame's byte 0 exactly 2 cycles after the first frame's `tlast` handshake; `local_mac` changed mid-frame does not alter the first frame.
- `rst` asserted at byte 20 → `tvalid`/`busy` low asynchronously; after release, `cmd_ready`=1 and a new command produces a complete, correct frame.
- Pad build vs. non-pad build → `tlast` at byte 59 vs. byte 41; bytes 42–59 all 0x00 in the pad build.

Source files
------------

// File: rtl/axi_udp_pkg.sv
// Shared protocol constants and helpers for the UDP offload stack.
package axi_udp_pkg;

  localparam logic [47:0] BROADCAST_MAC    = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
  localparam logic [15:0] ARP_HW_TYPE      = 16'h0001;
  localparam logic [15:0] ARP_PROTO_TYPE   = 16'h0800;
  localparam logic [7:0]  ARP_HW_SIZE      = 8'd6;
  localparam logic [7:0]  ARP_PROTO_SIZE   = 8'd4;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;

  localparam int ARP_FRAME_LEN     = 42;
  localparam int ETH_MIN_FRAME_LEN = 60;

  // Byte offsets of each field within the Ethernet+ARP frame.
  localparam int ARP_OFF_DA    = 0;
  localparam int ARP_OFF_SA    = 6;
  localparam int ARP_OFF_ETYPE = 12;
  localparam int ARP_OFF_HTYPE = 14;
  localparam int ARP_OFF_PTYPE = 16;
  localparam int ARP_OFF_HLEN  = 18;
  localparam int ARP_OFF_PLEN  = 19;
  localparam int ARP_OFF_OPER  = 20;
  localparam int ARP_OFF_SHA   = 22;
  localparam int ARP_OFF_SPA   = 28;
  localparam int ARP_OFF_THA   = 32;
  localparam int ARP_OFF_TPA   = 38;

  typedef struct packed {
    logic [15:0] oper;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_cmd_t;

  // Big-endian byte pickers: byte 0 is the most significant.
  function automatic logic [7:0] be_byte48(input logic [47:0] v, input int i);
    return v[8*(5-i) +: 8];
  endfunction

  function automatic logic [7:0] be_byte32(input logic [31:0] v, input int i);
    return v[8*(3-i) +: 8];
  endfunction

  function automatic logic [7:0] be_byte16(input logic [15:0] v, input int i);
    return v[8*(1-i) +: 8];
  endfunction

endpackage

// File: rtl/axi_udp_arp_tx.sv
// ARP request/reply frame serializer onto an 8-bit AXI4-Stream master.
// Define AXI_UDP_ARP_TX_PAD_EN to zero-pad frames to the 60-byte Ethernet minimum.
module axi_udp_arp_tx
  import axi_udp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_oper,
  input  logic [47:0] cmd_tha,
  input  logic [31:0] cmd_tpa,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy
);

`ifdef AXI_UDP_ARP_TX_PAD_EN
  localparam int FRAME_LEN = ETH_MIN_FRAME_LEN;
`else
  localparam int FRAME_LEN = ARP_FRAME_LEN;
`endif
  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e      state_q, state_d;
  arp_cmd_t    cmd_q, cmd_d, cmd_src;
  logic [47:0] mac_q, mac_d, mac_src;
  logic [31:0] ip_q, ip_d, ip_src;
  logic [5:0]  cnt_q, cnt_d, idx;
  logic [7:0]  tdata_q, tdata_d, byte_mux;
  logic        tlast_q, tlast_d;
  logic        accept, xfer, is_req;
  logic [47:0] da, tha_f;

  assign accept = (state_q == IDLE) && cmd_valid;
  assign xfer   = (state_q == SEND) && m_axis_tready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the latched command fields are reset too; they are a handful of flops, not a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      mac_q   <= '0;
      ip_q    <= '0;
      cnt_q   <= '0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      mac_q   <= mac_d;
      ip_q    <= ip_d;
      cnt_q   <= cnt_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
    end
  end

  always_comb begin
    // NOTE: assign a default first so no path through always_comb infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid) state_d = SEND;
      SEND: if (m_axis_tready && tlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte 0 is built straight from the inputs so it is valid the cycle after accept.
  always_comb begin
    cmd_src = accept ? '{oper: cmd_oper, tha: cmd_tha, tpa: cmd_tpa} : cmd_q;
    mac_src = accept ? local_mac : mac_q;
    ip_src  = accept ? local_ip  : ip_q;
    idx     = accept ? 6'd0 : cnt_q + 6'd1;
    is_req  = (cmd_src.oper == ARP_OPER_REQUEST);
    da      = is_req ? BROADCAST_MAC : cmd_src.tha;
    tha_f   = is_req ? 48'h0 : cmd_src.tha;
  end

  always_comb begin
    int i;
    i = int'(idx);
    if (i < ARP_OFF_SA)         byte_mux = be_byte48(da, i - ARP_OFF_DA);
    else if (i < ARP_OFF_ETYPE) byte_mux = be_byte48(mac_src, i - ARP_OFF_SA);
    else if (i < ARP_OFF_HTYPE) byte_mux = be_byte16(ETHERTYPE_ARP, i - ARP_OFF_ETYPE);
    else if (i < ARP_OFF_PTYPE) byte_mux = be_byte16(ARP_HW_TYPE, i - ARP_OFF_HTYPE);
    else if (i < ARP_OFF_HLEN)  byte_mux = be_byte16(ARP_PROTO_TYPE, i - ARP_OFF_PTYPE);
    else if (i < ARP_OFF_PLEN)  byte_mux = ARP_HW_SIZE;
    else if (i < ARP_OFF_OPER)  byte_mux = ARP_PROTO_SIZE;
    else if (i < ARP_OFF_SHA)   byte_mux = be_byte16(cmd_src.oper, i - ARP_OFF_OPER);
    else if (i < ARP_OFF_SPA)   byte_mux = be_byte48(mac_src, i - ARP_OFF_SHA);
    else if (i < ARP_OFF_THA)   byte_mux = be_byte32(ip_src, i - ARP_OFF_SPA);
    else if (i < ARP_OFF_TPA)   byte_mux = be_byte48(tha_f, i - ARP_OFF_THA);
    else if (i < ARP_FRAME_LEN) byte_mux = be_byte32(cmd_src.tpa, i - ARP_OFF_TPA);
    else                        byte_mux = 8'h00;
  end

  always_comb begin
    cmd_d   = cmd_q;
    mac_d   = mac_q;
    ip_d    = ip_q;
    cnt_d   = cnt_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    if (accept) begin
      cmd_d   = cmd_src;
      mac_d   = local_mac;
      ip_d    = local_ip;
      cnt_d   = 6'd0;
      tdata_d = byte_mux;
      tlast_d = (idx == LAST_IDX);
    end else if (xfer) begin
      if (tlast_q) begin
        tdata_d = 8'h00;
        tlast_d = 1'b0;
      end else begin
        cnt_d   = idx;
        tdata_d = byte_mux;
        tlast_d = (idx == LAST_IDX);
      end
    end
  end

  always_comb begin
    cmd_ready     = (state_q == IDLE) && !rst;
    m_axis_tvalid = (state_q == SEND);
    busy          = (state_q == SEND);
    m_axis_tdata  = tdata_q;
    m_axis_tlast  = tlast_q;
  end

endmodule

// File: tb/tb_axi_udp_arp_tx.sv
// Self-checking bench for axi_udp_arp_tx against a frame-level reference model.
module tb_axi_udp_arp_tx;

`ifdef AXI_UDP_ARP_TX_PAD_EN
  localparam int FRAME_LEN = 60;
`else
  localparam int FRAME_LEN = 42;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] local_mac;
  logic [31:0] local_ip;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_oper;
  logic [47:0] cmd_tha;
  logic [31:0] cmd_tpa;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_b [0:59];

  always #5 clk = ~clk;

  axi_udp_arp_tx dut (
    .clk(clk), .rst(rst), .local_mac(local_mac), .local_ip(local_ip),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_oper(cmd_oper),
    .cmd_tha(cmd_tha), .cmd_tpa(cmd_tpa), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy)
  );

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: whole header laid out as one big-endian vector, then padding.
  task automatic build_exp(input logic [15:0] oper, input logic [47:0] tha, input logic [31:0] tpa);
    logic [335:0] hdr;
    bit req;
    req = (oper == 16'd1);
    hdr = {req ? 48'hFFFF_FFFF_FFFF : tha, local_mac, 16'h0806, 16'h0001, 16'h0800,
           8'h06, 8'h04, oper, local_mac, local_ip, req ? 48'h0 : tha, tpa};
    for (int i = 0; i < 60; i++) exp_b[i] = (i < 42) ? hdr[335 - 8*i -: 8] : 8'h00;
  endtask

  // Presents a command, checks acceptance and that byte 0 is valid one cycle later.
  task automatic issue(input logic [15:0] oper, input logic [47:0] tha, input logic [31:0] tpa,
                       input bit hold);
    @(negedge clk);
    cmd_oper  = oper;
    cmd_tha   = tha;
    cmd_tpa   = tpa;
    cmd_valid = 1'b1;
    check("cmd_ready_idle", {47'd0, cmd_ready}, 48'd1);
    build_exp(oper, tha, tpa);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    check("byte0_latency", {47'd0, m_axis_tvalid}, 48'd1);
  endtask

  // Consumes one frame starting at the current negedge; returns at the negedge after tlast.
  task automatic collect(input bit bp, input int abort_at, input int mac_at);
    int idx = 0;
    int cyc = 0;
    bit done = 1'b0;
    bit stalled = 1'b0;
    bit mac_done = 1'b0;
    logic [7:0] held_d = 8'h00;
    logic held_l = 1'b0;
    check("ready_low_in_frame", {47'd0, cmd_ready}, 48'd0);
    while (!done && cyc < 1000) begin
      if (idx == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_tvalid", {47'd0, m_axis_tvalid}, 48'd0);
        check("abort_busy", {47'd0, busy}, 48'd0);
        check("abort_ready", {47'd0, cmd_ready}, 48'd0);
        check("abort_tlast", {47'd0, m_axis_tlast}, 48'd0);
        check("abort_tdata", {40'd0, m_axis_tdata}, 48'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_abort_ready", {47'd0, cmd_ready}, 48'd1);
        m_axis_tready = 1'b1;
        return;
      end
      if (idx == mac_at && !mac_done) begin
        local_mac = {$urandom, $urandom} & 48'hFEFF_FFFF_FFFF;
        mac_done = 1'b1;
      end
      check("tvalid_held", {47'd0, m_axis_tvalid}, 48'd1);
      if (stalled) begin
        check("stall_tdata", {40'd0, m_axis_tdata}, {40'd0, held_d});
        check("stall_tlast", {47'd0, m_axis_tlast}, {47'd0, held_l});
      end
      m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        check($sformatf("byte%0d", idx), {40'd0, m_axis_tdata}, {40'd0, exp_b[idx]});
        check($sformatf("tlast%0d", idx), {47'd0, m_axis_tlast}, {47'd0, idx == FRAME_LEN - 1});
        if (m_axis_tlast) done = 1'b1;
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_d  = m_axis_tdata;
        held_l  = m_axis_tlast;
      end
      @(negedge clk);
      cyc++;
    end
    m_axis_tready = 1'b1;
    check("frame_done", {47'd0, done}, 48'd1);
    check("frame_len", 48'(idx), 48'(FRAME_LEN));
    check("gap_tvalid", {47'd0, m_axis_tvalid}, 48'd0);
    check("gap_ready", {47'd0, cmd_ready}, 48'd1);
  endtask

  initial begin
    logic [15:0] op;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_oper = '0;
    cmd_tha = '0;
    cmd_tpa = '0;
    m_axis_tready = 1'b1;
    local_mac = 48'h02_00_00_00_00_01;
    local_ip  = 32'h0A_00_00_01;
    #2;
    check("rst_ready", {47'd0, cmd_ready}, 48'd0);
    check("rst_tvalid", {47'd0, m_axis_tvalid}, 48'd0);
    check("rst_tlast", {47'd0, m_axis_tlast}, 48'd0);
    check("rst_tdata", {40'd0, m_axis_tdata}, 48'd0);
    check("rst_busy", {47'd0, busy}, 48'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_ready", {47'd0, cmd_ready}, 48'd1);
    check("idle_busy", {47'd0, busy}, 48'd0);

    // Directed reply, then request, then the reply again under backpressure.
    issue(16'd2, 48'hAA_BB_CC_DD_EE_FF, 32'h0A_00_00_02, 1'b0);
    collect(1'b0, -1, -1);
    issue(16'd1, {$urandom, $urandom}, 32'hC0_A8_01_0A, 1'b0);
    collect(1'b0, -1, -1);
    issue(16'd2, 48'hAA_BB_CC_DD_EE_FF, 32'h0A_00_00_02, 1'b0);
    collect(1'b1, -1, -1);

    // cmd_valid held across two frames, with local_mac changed mid-frame.
    issue(16'd2, 48'h11_22_33_44_55_66, 32'h0A_00_00_07, 1'b1);
    collect(1'b0, -1, 10);
    build_exp(16'd2, 48'h11_22_33_44_55_66, 32'h0A_00_00_07);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_byte0_gap", {47'd0, m_axis_tvalid}, 48'd1);
    collect(1'b0, -1, -1);

    // Reset in the middle of byte 20, then a clean frame.
    issue(16'd2, 48'hAA_BB_CC_DD_EE_FF, 32'h0A_00_00_02, 1'b0);
    collect(1'b0, 20, -1);
    issue(16'd1, 48'h0, 32'h0A_00_00_09, 1'b0);
    collect(1'b0, -1, -1);

    // Random commands, including illegal opcodes, with random backpressure.
    for (int n = 0; n < 6; n++) begin
      case ($urandom_range(0, 2))
        0: op = 16'd1;
        1: op = 16'd2;
        default: op = 16'($urandom_range(3, 65535));
      endcase
      local_mac = {$urandom, $urandom};
      local_ip  = $urandom;
      issue(op, {$urandom, $urandom}, $urandom, 1'b0);
      collect(1'($urandom_range(0, 1)), -1, 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
